// File: rtl/cla_slice_seq_adder.sv
// Sequential N-bit adder: one SLICE-bit carry-lookahead group per clock, LSB slice first,
// with the group carry registered between slices and valid/ready handshakes on both sides.
module cla_slice_seq_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  input  logic             C_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM_OUT,
  output logic             C_OUT,
  output logic             OVF
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout, r_ovf;

  logic [SLICE-1:0]   w_a_sl, w_b_sl, w_g, w_p, w_sum_sl;
  logic [SLICE:0]     w_c;
  logic               w_last, w_accept;

  // Flat sum-of-products lookahead: every carry is built straight from g/p and c0,
  // never from the previous bit's carry.
  function automatic logic [SLICE:0] lookahead(input logic [SLICE-1:0] g,
                                               input logic [SLICE-1:0] p,
                                               input logic             c0);
    logic [SLICE:0] c;
    logic           t;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < SLICE; i++) begin
      t = c0;
      for (int j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      for (int k = 0; k <= i; k++) begin
        t = g[k];
        for (int j = k + 1; j <= i; j++) t = t & p[j];
        c[i+1] = c[i+1] | t;
      end
    end
    return c;
  endfunction

  assign w_a_sl   = r_a[r_cnt * SLICE +: SLICE];
  assign w_b_sl   = r_b[r_cnt * SLICE +: SLICE];
  assign w_g      = w_a_sl & w_b_sl;
  assign w_p      = w_a_sl ^ w_b_sl;
  assign w_c      = lookahead(w_g, w_p, r_carry);
  assign w_sum_sl = w_p ^ w_c[SLICE-1:0];
  assign w_last   = (r_cnt == CNT_W'(NSLICE - 1));
  assign w_accept = (r_state == S_IDLE) && IN_VALID;

  always_comb begin
    w_state_nxt = r_state;
    IN_READY    = 1'b0;
    OUT_VALID   = 1'b0;
    case (r_state)
      S_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands are only ever loaded at acceptance, so they need no reset.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_a <= A_IN;
      r_b <= B_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_carry <= C_IN;
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_sum[r_cnt * SLICE +: SLICE] <= w_sum_sl;
        r_carry <= w_c[SLICE];
        if (w_last) begin
          r_cnt  <= '0;
          r_cout <= w_c[SLICE];
          r_ovf  <= w_c[SLICE] ^ w_c[SLICE-1];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign SUM_OUT = r_sum;
  assign C_OUT   = r_cout;
  assign OVF     = r_ovf;

endmodule

// File: tb/tb_cla_slice_seq_adder.sv
// Directed and random bench for cla_slice_seq_adder using an expected-result queue.
module tb_cla_slice_seq_adder;

  localparam int W      = 16;
  localparam int S      = 4;
  localparam int NSLICE = W / S;

  logic         CLK = 1'b0;
  logic         RST_N, IN_VALID, IN_READY, C_IN, OUT_VALID, OUT_READY, C_OUT, OVF;
  logic [W-1:0] A_IN, B_IN, SUM_OUT;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];

  cla_slice_seq_adder #(.WIDTH(W), .SLICE(S)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A_IN(A_IN), .B_IN(B_IN), .C_IN(C_IN), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .SUM_OUT(SUM_OUT), .C_OUT(C_OUT), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] full;
    exp_t       e;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  // Runs one transaction; called with inputs settled at a negedge, returns at a negedge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int stall, input bit noisy);
    int   guard;
    int   lat;
    exp_t e;
    guard = 0;
    while (!IN_READY && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    chk("in_ready_wait", IN_READY, 1);
    A_IN = a; B_IN = b; C_IN = c; IN_VALID = 1'b1; OUT_READY = 1'b0;
    sb.push_back(model(a, b, c));
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = noisy;
    if (noisy) begin A_IN = W'($urandom); B_IN = W'($urandom); C_IN = 1'($urandom); end
    lat = 0;
    while (!OUT_VALID && lat < 20) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      if (noisy) begin A_IN = W'($urandom); B_IN = W'($urandom); end
    end
    chk("latency", lat, NSLICE);
    chk("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '0;
    chk("sum", SUM_OUT, e.sum);
    chk("cout", C_OUT, e.cout);
    chk("ovf", OVF, e.ovf);
    for (int i = 0; i < stall; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (noisy) begin A_IN = W'($urandom); B_IN = W'($urandom); end
      chk("stall_valid", OUT_VALID, 1);
      chk("stall_in_ready", IN_READY, 0);
      chk("stall_sum", SUM_OUT, e.sum);
      chk("stall_cout", C_OUT, e.cout);
      chk("stall_ovf", OVF, e.ovf);
    end
    OUT_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    OUT_READY = 1'b0;
    IN_VALID  = 1'b0;
    chk("in_ready_back", IN_READY, 1);
    chk("out_valid_drop", OUT_VALID, 0);
  endtask

  initial begin
    RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; A_IN = '0; B_IN = '0; C_IN = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_in_ready", IN_READY, 1);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_sum", SUM_OUT, 16'h0000);
    chk("rst_cout", C_OUT, 0);
    chk("rst_ovf", OVF, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    run_op(16'h1234, 16'h4321, 1'b1, 0, 1'b0);
    chk("dir_sum_5556", SUM_OUT, 16'h5556);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    chk("dir_carry_chain", {C_OUT, SUM_OUT}, 17'h1_0000);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    chk("dir_pos_ovf", {OVF, SUM_OUT}, 17'h1_8000);
    run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
    chk("dir_neg_ovf", {OVF, C_OUT, SUM_OUT}, 18'h3_0000);

    // Backpressure with noisy inputs, then immediate follow-on operation.
    run_op(16'hA5A5, 16'h1111, 1'b1, 5, 1'b1);
    run_op(16'h0F0F, 16'hF0F0, 1'b1, 0, 1'b0);
    chk("follow_on", {C_OUT, SUM_OUT}, 17'h1_0000);

    // Reset during the third slice of a run.
    A_IN = 16'hAAAA; B_IN = 16'h5555; C_IN = 1'b1; IN_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    chk("midrst_in_ready", IN_READY, 1);
    chk("midrst_out_valid", OUT_VALID, 0);
    chk("midrst_sum", SUM_OUT, 16'h0000);
    run_op(16'h00FF, 16'h0F01, 1'b0, 0, 1'b0);
    chk("post_rst_sum", {C_OUT, SUM_OUT}, 17'h0_1000);

    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      case ($urandom_range(0, 5))
        0:       begin ra = '1; rb = W'($urandom); end
        1:       begin ra = {1'b0, {(W-1){1'b1}}}; rb = W'($urandom_range(0, 3)); end
        2:       begin ra = {1'b1, {(W-1){1'b0}}}; rb = {1'b1, W'($urandom) >> 1}; end
        default: begin ra = W'($urandom); rb = W'($urandom); end
      endcase
      run_op(ra, rb, 1'($urandom), $urandom_range(0, 3), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
